// File: rtl/alu_vector_checker.sv
// Synthesizable self-check stage for the 32-bit ALU: streams test vectors in,
// drives the ALU, compares its result after a settle window and keeps statistics.
module alu_vector_checker #(
  parameter int WIDTH         = 32,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  output logic             vec_ready,
  input  logic [2:0]       vec_f,
  input  logic [WIDTH-1:0] vec_a,
  input  logic [WIDTH-1:0] vec_b,
  input  logic [WIDTH-1:0] vec_y,
  input  logic             vec_zero,
  input  logic             vec_last,
  output logic [2:0]       alu_f,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [CNT_W-1:0] first_fail_idx,
  output logic             first_fail_valid,
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_y,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {IDLE, FETCH, SETTLE, CHECK, DONE} state_t;

  localparam int                SET_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SET_W-1:0]  SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;

  state_t             state;
  logic [SET_W-1:0]   settle_cnt;
  logic [WIDTH-1:0]   exp_y;
  logic               exp_zero;
  logic               exp_last;
  logic [CNT_W-1:0]   vec_idx;
  logic               result_ok;

  assign result_ok = (alu_y == exp_y) && (alu_zero == exp_zero);

  // Status flags (vec_ready/busy/done) are registered alongside the state so
  // they never depend combinationally on the stream inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      settle_cnt       <= '0;
      exp_y            <= '0;
      exp_zero         <= 1'b0;
      exp_last         <= 1'b0;
      vec_idx          <= '0;
      alu_f            <= '0;
      alu_a            <= '0;
      alu_b            <= '0;
      pass_cnt         <= '0;
      fail_cnt         <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
      mismatch         <= 1'b0;
      mismatch_y       <= '0;
      vec_ready        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            pass_cnt         <= '0;
            fail_cnt         <= '0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
            mismatch_y       <= '0;
            vec_idx          <= '0;
            state            <= FETCH;
            vec_ready        <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
          end
        end
        FETCH: begin
          if (vec_valid && vec_ready) begin
            alu_f      <= vec_f;
            alu_a      <= vec_a;
            alu_b      <= vec_b;
            exp_y      <= vec_y;
            exp_zero   <= vec_zero;
            exp_last   <= vec_last;
            settle_cnt <= '0;
            vec_ready  <= 1'b0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CHECK;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (result_ok) begin
            if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
            mismatch   <= 1'b1;
            mismatch_y <= alu_y;
            if (!first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_idx;
            end
          end
          if (vec_idx != CNT_MAX) vec_idx <= vec_idx + 1'b1;
          if (exp_last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state     <= FETCH;
            vec_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          vec_ready <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
